// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- hazard / stall / flush controller for a 5-stage in-order pipeline
//
// Merges the per-stage hold requests into a per-register stall vector. It also
// sequences multi-cycle EX operations: a small IDLE/BUSY FSM with a down-counter
// holds EX for the full operation length. Redirect requests are registered into
// a one-cycle flush pulse that carries the new PC.
//
// Ports
//   clk           in   single clock, all state updates on posedge
//   rst           in   synchronous, active-high reset
//   id_stallreq   in   ID hold request (load-use, operand not ready)
//   ex_stallreq   in   EX hold request (external)
//   mem_stallreq  in   MEM hold request (bus wait)
//   mc_start      in   EX begins a multi-cycle op this cycle
//   mc_len        in   total EX cycles of that op (0/1 = no hold)
//   flush_req     in   redirect request (mispredict / exception)
//   flush_pc      in   redirect target, sampled with flush_req
//   stall[4:0]    out  hold per register: PC, IF/ID, ID/EX, EX/MEM, MEM/WB
//   flush         out  clear all pipeline registers and load new_pc into PC
//   new_pc        out  redirect target (valid while flush=1, else last target)
//   mc_busy       out  a multi-cycle op is holding EX
//   mc_done       out  final cycle of a multi-cycle op
// -----------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int PC_W     = 32,
    parameter int MC_LEN_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_stallreq,
    input  logic                ex_stallreq,
    input  logic                mem_stallreq,
    input  logic                mc_start,
    input  logic [MC_LEN_W-1:0] mc_len,
    input  logic                flush_req,
    input  logic [PC_W-1:0]     flush_pc,
    output logic [4:0]          stall,
    output logic                flush,
    output logic [PC_W-1:0]     new_pc,
    output logic                mc_busy,
    output logic                mc_done
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [MC_LEN_W-1:0] cnt_reg, cnt_next;

    // Redirect bookkeeping: a pending flag with its target, plus the last
    // target actually issued so new_pc stays stable between flushes.
    logic                pend_reg, pend_next;
    logic [PC_W-1:0]     tgt_reg, tgt_next;
    logic [PC_W-1:0]     new_pc_reg, new_pc_next;

    logic                flush_int;
    logic                mc_go;
    logic                ex_hold;
    logic [2:0]          hold_depth;

    // A pending redirect is issued as soon as MEM is not holding; a bus wait
    // cannot be flushed away, so the redirect waits for it.
    assign flush_int = pend_reg && !mem_stallreq;

    // A length of 0 or 1 completes in a single EX cycle and needs no hold.
    assign mc_go = mc_start && (mc_len > MC_LEN_W'(1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            pend_reg   <= 1'b0;
            tgt_reg    <= '0;
            new_pc_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            pend_reg   <= pend_next;
            tgt_reg    <= tgt_next;
            new_pc_reg <= new_pc_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;

        if (flush_int) begin
            // A redirect kills any in-flight multi-cycle op, and a start
            // presented in the flush cycle belongs to a squashed instruction.
            state_next = ST_IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (mc_go) begin
                        // Cycle N is already held combinationally, so BUSY
                        // covers the remaining L-1 cycles: cnt runs L-2..0.
                        state_next = ST_BUSY;
                        cnt_next   = mc_len - MC_LEN_W'(2);
                    end
                end
                ST_BUSY: begin
                    if (cnt_reg == '0) begin
                        state_next = ST_IDLE;
                    end else begin
                        cnt_next = cnt_reg - MC_LEN_W'(1);
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_comb begin
        pend_next   = pend_reg;
        tgt_next    = tgt_reg;
        new_pc_next = new_pc_reg;

        if (flush_int) begin
            new_pc_next = tgt_reg;
        end

        // A new request always wins: it overwrites a waiting target, and a
        // request arriving in the flush cycle re-arms for a second flush.
        if (flush_req) begin
            pend_next = 1'b1;
            tgt_next  = flush_pc;
        end else if (flush_int) begin
            pend_next = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        mc_busy = (state_reg == ST_BUSY);
        mc_done = (state_reg == ST_BUSY) && (cnt_reg == '0) && !flush_int;
        flush   = flush_int;
        new_pc  = flush_int ? tgt_reg : new_pc_reg;

        ex_hold = ex_stallreq || (state_reg == ST_BUSY) ||
                  (mc_go && (state_reg == ST_IDLE));

        // hold_depth = number of registers (from the PC upward) that hold.
        // The first non-held register downstream loads a bubble.
        hold_depth = 3'd0;
        if (flush_int) begin
            hold_depth = 3'd0;
        end else if (mem_stallreq) begin
            hold_depth = 3'd4;
        end else if (ex_hold) begin
            hold_depth = 3'd3;
        end else if (id_stallreq) begin
            hold_depth = 3'd2;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_stall
            assign stall[gi] = (hold_depth > 3'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl -- scoreboard bench for pipe_ctrl.
// The stimulus process drives one cycle at a time. It computes that cycle's
// expected outputs from a behavioural model (remaining-hold counter, pending
// redirect) and queues them. The monitor pops one entry per cycle on the
// falling edge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam int PC_W     = 32;
    localparam int MC_LEN_W = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                id_stallreq, ex_stallreq, mem_stallreq;
    logic                mc_start;
    logic [MC_LEN_W-1:0] mc_len;
    logic                flush_req;
    logic [PC_W-1:0]     flush_pc;
    logic [4:0]          stall;
    logic                flush;
    logic [PC_W-1:0]     new_pc;
    logic                mc_busy, mc_done;

    always #5 clk = ~clk;

    pipe_ctrl #(.PC_W(PC_W), .MC_LEN_W(MC_LEN_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_stallreq  (id_stallreq),
        .ex_stallreq  (ex_stallreq),
        .mem_stallreq (mem_stallreq),
        .mc_start     (mc_start),
        .mc_len       (mc_len),
        .flush_req    (flush_req),
        .flush_pc     (flush_pc),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .mc_busy      (mc_busy),
        .mc_done      (mc_done)
    );

    typedef struct {
        logic [4:0]      stall;
        logic            flush;
        logic [PC_W-1:0] pc;
        logic            busy;
        logic            done;
        int              cyc;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state
    int              m_busy_left = 0;   // BUSY cycles still to come (incl. current)
    bit              m_pend      = 0;
    logic [PC_W-1:0] m_tgt       = '0;
    logic [PC_W-1:0] m_last_pc   = '0;

    task automatic step(input bit r, input bit id, input bit ex, input bit mem,
                        input bit st, input int len, input bit fr,
                        input logic [PC_W-1:0] fpc);
        exp_t e;
        bit   f;
        bit   busy;
        bit   hold;
        @(posedge clk);
        #1;
        cyc++;
        rst          = r;
        id_stallreq  = id;
        ex_stallreq  = ex;
        mem_stallreq = mem;
        mc_start     = st;
        mc_len       = MC_LEN_W'(len);
        flush_req    = fr;
        flush_pc     = fpc;

        f    = m_pend && !mem;
        busy = (m_busy_left > 0);
        hold = ex || busy || (st && len >= 2 && !busy);
        e.flush = f;
        e.pc    = f ? m_tgt : m_last_pc;
        e.busy  = busy;
        e.done  = (m_busy_left == 1) && !f;
        e.stall = f ? 5'b00000 : mem ? 5'b01111 : hold ? 5'b00111 :
                  id ? 5'b00011 : 5'b00000;
        e.cyc   = cyc;
        exp_q.push_back(e);

        if (r) begin
            m_busy_left = 0;
            m_pend      = 0;
            m_tgt       = '0;
            m_last_pc   = '0;
        end else begin
            if (f) m_busy_left = 0;
            else if (busy) m_busy_left--;
            else if (st && len >= 2) m_busy_left = len - 1;
            if (f) m_last_pc = m_tgt;
            if (fr) begin
                m_pend = 1;
                m_tgt  = fpc;
            end else if (f) begin
                m_pend = 0;
            end
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, '0);
    endtask

    task automatic chk(input string name, input int c,
                       input logic [PC_W-1:0] act, input logic [PC_W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h, expected %h", name, c, act, req);
        end
    endtask

    // Monitor: one expected entry per cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("stall",   e.cyc, PC_W'(stall),   PC_W'(e.stall));
                chk("flush",   e.cyc, PC_W'(flush),   PC_W'(e.flush));
                chk("new_pc",  e.cyc, new_pc,         e.pc);
                chk("mc_busy", e.cyc, PC_W'(mc_busy), PC_W'(e.busy));
                chk("mc_done", e.cyc, PC_W'(mc_done), PC_W'(e.done));
                $display("cycle %0d: stall=%b flush=%b new_pc=%h busy=%b done=%b",
                         e.cyc, stall, flush, new_pc, mc_busy, mc_done);
            end
        end
    end

    initial begin
        rst = 1'b1; id_stallreq = 0; ex_stallreq = 0; mem_stallreq = 0;
        mc_start = 0; mc_len = '0; flush_req = 0; flush_pc = '0;
        @(posedge clk);

        // Reset state
        step(1, 0, 0, 0, 0, 0, 0, '0);
        idle();

        // Stall priority build-up
        step(0, 1, 0, 0, 0, 0, 0, '0);
        step(0, 1, 1, 0, 0, 0, 0, '0);
        step(0, 1, 1, 1, 0, 0, 0, '0);
        idle();

        // Multi-cycle length 4, then length 1, 0 and 2
        step(0, 0, 0, 0, 1, 4, 0, '0);
        repeat (5) idle();
        step(0, 0, 0, 0, 1, 1, 0, '0);
        step(0, 0, 0, 0, 1, 0, 0, '0);
        step(0, 0, 0, 0, 1, 2, 0, '0);
        repeat (2) idle();

        // Plain flush
        step(0, 0, 0, 0, 0, 0, 1, 32'h0000_0040);
        repeat (2) idle();

        // Flush held off by a bus wait
        step(0, 0, 0, 1, 0, 0, 1, 32'h0000_0080);
        repeat (3) step(0, 0, 0, 1, 0, 0, 0, '0);
        repeat (2) idle();

        // Flush kills a multi-cycle op; start in flush cycle ignored
        step(0, 0, 0, 0, 1, 6, 0, '0);
        idle();
        step(0, 0, 0, 0, 0, 0, 1, 32'h0000_0100);
        step(0, 0, 0, 0, 1, 5, 0, '0);
        repeat (3) idle();

        // Back-to-back flush requests: second issued the following cycle
        step(0, 0, 0, 0, 0, 0, 1, 32'h0000_0200);
        step(0, 0, 0, 0, 0, 0, 1, 32'h0000_0300);
        repeat (2) idle();

        // Reset mid-BUSY with a pending flush
        step(0, 0, 0, 0, 1, 5, 0, '0);
        step(0, 0, 0, 1, 0, 0, 1, 32'h0000_0400);
        step(1, 0, 0, 1, 1, 7, 1, 32'h0000_0500);
        repeat (8) idle();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 15)),
                 ($urandom_range(0, 7) == 0),
                 $urandom());
        end

        repeat (3) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
